// File: rtl/audio_framer.sv
// Overlapping frame generator: stores the latest SAMPLES audio samples in a circular buffer and
// replays the whole buffer, oldest sample first, every HOP new samples.
module audio_framer #(
  parameter int SAMPLES = 512,
  parameter int HOP     = 256,
  parameter int WIDTH   = 16
) (
  input  logic                         clk_in,
  input  logic                         rst_in,
  input  logic signed [WIDTH-1:0]      audio_data_in,
  input  logic                         audio_valid_in,
  output logic [$clog2(SAMPLES)-1:0]   sample_out,
  output logic signed [WIDTH-1:0]      audio_data_out,
  output logic                         audio_valid_out,
  output logic                         frame_last_out,
  output logic                         frame_drop_out
);
  localparam int AW = $clog2(SAMPLES);
  localparam int HW = $clog2(HOP + 1);
  localparam logic [AW-1:0] LAST_IDX = AW'(SAMPLES - 1);
  localparam logic [HW-1:0] HOP_MAX  = HW'(HOP - 1);

  typedef enum logic [1:0] {S_FILL, S_WAIT, S_STREAM} state_t;

  logic signed [WIDTH-1:0] mem [SAMPLES];
  logic signed [WIDTH-1:0] rd_data_q;

  state_t                  state_q, state_d;
  logic [AW-1:0]           wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]           fill_cnt_q, fill_cnt_d;
  logic [HW-1:0]           hop_cnt_q, hop_cnt_d;
  logic [AW-1:0]           rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]           rd_cnt_q, rd_cnt_d;
  logic                    rd_vld_q, rd_vld_d;
  logic [AW-1:0]           rd_idx_q, rd_idx_d;
  logic                    valid_q, valid_d;
  logic [AW-1:0]           sample_q, sample_d;
  logic                    last_q, last_d;
  logic                    drop_q, drop_d;
  logic signed [WIDTH-1:0] data_q, data_d;

  logic reading, fill_hit, hop_hit;

  always_comb begin
    reading  = (state_q == S_STREAM);
    fill_hit = audio_valid_in && (state_q == S_FILL) && (fill_cnt_q == LAST_IDX);
    hop_hit  = audio_valid_in && (state_q != S_FILL) && (hop_cnt_q == HOP_MAX);

    state_d    = state_q;
    wr_ptr_d   = audio_valid_in ? wr_ptr_q + AW'(1) : wr_ptr_q;
    fill_cnt_d = fill_cnt_q;
    hop_cnt_d  = hop_cnt_q;
    rd_ptr_d   = reading ? rd_ptr_q + AW'(1) : rd_ptr_q;
    rd_cnt_d   = reading ? rd_cnt_q + AW'(1) : rd_cnt_q;
    drop_d     = hop_hit && reading;

    if (state_q == S_FILL) begin
      if (audio_valid_in) fill_cnt_d = fill_cnt_q + AW'(1);
    end else if (audio_valid_in) begin
      hop_cnt_d = hop_hit ? '0 : hop_cnt_q + HW'(1);
    end

    case (state_q)
      S_FILL:   if (fill_hit) state_d = S_STREAM;
      S_WAIT:   if (hop_hit) state_d = S_STREAM;
      S_STREAM: if (rd_cnt_q == LAST_IDX) state_d = S_WAIT;
      default:  state_d = S_FILL;
    endcase

    // Frame start: the slot about to be overwritten next is the oldest stored sample.
    if (!reading && (fill_hit || hop_hit)) begin
      rd_ptr_d = wr_ptr_d;
      rd_cnt_d = '0;
    end

    rd_vld_d = reading;
    rd_idx_d = rd_cnt_q;
    valid_d  = rd_vld_q;
    sample_d = rd_vld_q ? rd_idx_q : '0;
    last_d   = rd_vld_q && (rd_idx_q == LAST_IDX);
    data_d   = rd_vld_q ? rd_data_q : '0;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q    <= S_FILL;
      wr_ptr_q   <= '0;
      fill_cnt_q <= '0;
      hop_cnt_q  <= '0;
      rd_ptr_q   <= '0;
      rd_cnt_q   <= '0;
      rd_vld_q   <= 1'b0;
      rd_idx_q   <= '0;
      valid_q    <= 1'b0;
      sample_q   <= '0;
      last_q     <= 1'b0;
      drop_q     <= 1'b0;
      data_q     <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      fill_cnt_q <= fill_cnt_d;
      hop_cnt_q  <= hop_cnt_d;
      rd_ptr_q   <= rd_ptr_d;
      rd_cnt_q   <= rd_cnt_d;
      rd_vld_q   <= rd_vld_d;
      rd_idx_q   <= rd_idx_d;
      valid_q    <= valid_d;
      sample_q   <= sample_d;
      last_q     <= last_d;
      drop_q     <= drop_d;
      data_q     <= data_d;
    end
  end

  // Read-before-write: a same-slot read sees the old sample, which is the one the frame needs.
  always_ff @(posedge clk_in) begin
    if (audio_valid_in && !rst_in) mem[wr_ptr_q] <= audio_data_in;
    if (reading) rd_data_q <= mem[rd_ptr_q];
  end

  assign sample_out      = sample_q;
  assign audio_data_out  = data_q;
  assign audio_valid_out = valid_q;
  assign frame_last_out  = last_q;
  assign frame_drop_out  = drop_q;
endmodule

// File: tb/tb_audio_framer.sv
// Randomized scoreboard bench for audio_framer: two instances (HOP=256 and HOP=SAMPLES) share
// one input stream; a sample-history model predicts every frame beat and drop pulse.
module tb_audio_framer;
  localparam int S = 512;

  typedef struct {
    int                 cyc;
    logic signed [15:0] data;
    int                 idx;
  } exp_t;

  logic               clk = 1'b0;
  logic               rst;
  logic               vin;
  logic signed [15:0] din;
  int                 checks = 0;
  int                 failures = 0;
  int                 pending [2];

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int inst, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s inst=%0d t=%0t actual=%h expected=%h", nm, inst, $time, act, exp);
    end
  endtask

  for (genvar gi = 0; gi < 2; gi++) begin : g_inst
    localparam int H = (gi == 0) ? 256 : 512;
    logic [8:0]         so;
    logic signed [15:0] dout;
    logic               vo, lo, dr;

    audio_framer #(.SAMPLES(S), .HOP(H), .WIDTH(16)) dut (
      .clk_in(clk), .rst_in(rst), .audio_data_in(din), .audio_valid_in(vin),
      .sample_out(so), .audio_data_out(dout), .audio_valid_out(vo),
      .frame_last_out(lo), .frame_drop_out(dr)
    );

    exp_t               sb [$];
    logic signed [15:0] hist [$];
    int edge_n = 0, fill_n = 0, hop_n = 0, busy_until = 0, drop_edge = -1;

    // Reference: a frame is the last S accepted samples, emitted from edge E+2 onward;
    // a trigger while a previous frame is still being read (edges E+1..E+S) is dropped.
    initial forever begin
      bit trig;
      @(posedge clk);
      edge_n++;
      if (rst) begin
        fill_n = 0; hop_n = 0; busy_until = 0; drop_edge = -1;
        hist.delete(); sb.delete();
      end else if (vin) begin
        hist.push_back(din);
        if (hist.size() > S) void'(hist.pop_front());
        trig = 0;
        if (fill_n < S) begin
          fill_n++;
          trig = (fill_n == S);
        end else begin
          hop_n++;
          if (hop_n == H) begin hop_n = 0; trig = 1; end
        end
        if (trig) begin
          if (edge_n <= busy_until) drop_edge = edge_n;
          else begin
            for (int k = 0; k < S; k++) sb.push_back('{edge_n + 2 + k, hist[k], k});
            busy_until = edge_n + S;
          end
        end
      end
      pending[gi] = sb.size();
    end

    initial forever begin
      exp_t e;
      @(negedge clk);
      chk("drop", gi, {31'd0, dr}, {31'd0, drop_edge == edge_n});
      if (sb.size() > 0 && sb[0].cyc == edge_n) begin
        e = sb.pop_front();
        pending[gi] = sb.size();
        chk("valid", gi, {31'd0, vo}, 32'd1);
        chk("data", gi, 32'(dout), 32'(e.data));
        chk("index", gi, {23'd0, so}, 32'(e.idx));
        chk("last", gi, {31'd0, lo}, {31'd0, e.idx == S - 1});
      end else begin
        chk("idle_valid", gi, {31'd0, vo}, 32'd0);
        chk("idle_last", gi, {31'd0, lo}, 32'd0);
      end
    end
  end

  task automatic step(input logic v, input logic signed [15:0] d);
    vin = v;
    din = d;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1'b0, '0);
    step(1'b0, '0);
    rst = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, '0);
  endtask

  initial begin
    rst = 1'b1; vin = 1'b0; din = '0;
    repeat (3) step(1'b0, '0);
    rst = 1'b0;

    // Sparse fill (0..511) then 256 more samples (512..767)
    for (int i = 0; i < 768; i++) begin
      step(1'b1, 16'(i));
      idle(3);
    end
    idle(600);

    // One sample short of a full buffer: nothing must come out
    do_reset();
    for (int n = 0; n < 511; ) begin
      logic v;
      v = 1'($urandom_range(0, 1));
      step(v, 16'($urandom));
      if (v) n++;
    end
    idle(600);

    // Dense input 1000+i: overwrites race the read pointer, triggers land mid-stream
    do_reset();
    for (int i = 0; i < 2000; i++) step(1'b1, 16'(1000 + i));
    idle(600);

    // Nearly dense random input with rare gaps
    do_reset();
    for (int i = 0; i < 2500; i++) step(1'($urandom_range(0, 63) != 0), 16'($urandom));
    idle(600);

    // Reset around beat 100 of a frame, then a sparse refill
    do_reset();
    for (int i = 0; i < S; i++) step(1'b1, 16'($urandom));
    idle(100);
    rst = 1'b1;
    step(1'b0, '0);
    rst = 1'b0;
    for (int i = 0; i < S; i++) begin
      step(1'b1, 16'($urandom));
      idle(1);
    end
    idle(700);

    chk("drained", 0, 32'(pending[0]), 32'd0);
    chk("drained", 1, 32'(pending[1]), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
